// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
// State encodings are fixed so external checkers can decode the debug state port.
package prod_accum_pkg;

    localparam int ACC_W_DEF = 18;
    localparam int CNT_W_DEF = 4;
    localparam int PROD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating signed add of a 16-bit product into an ACC_W accumulator.
// o_sat flags that the true sum did not fit and o_sum holds the clamped value.
module sat_add
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_sat
);

    logic [ACC_W:0] w_full;

    // One guard bit: overflow exactly when the guard bit disagrees with the result sign.
    assign w_full = {i_acc[ACC_W-1], i_acc}
                  + {{(ACC_W + 1 - PROD_W){i_prod[PROD_W-1]}}, i_prod};
    assign o_sat  = w_full[ACC_W] ^ w_full[ACC_W-1];

    always_comb begin
        o_sum = w_full[ACC_W-1:0];
        if (o_sat) begin
            o_sum = w_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/prod_accum.sv
// Accumulates a programmed number of signed products with saturation, then
// presents the result until the consumer takes it.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_length,
    input  logic [PROD_W-1:0] i_product,
    input  logic              i_prod_valid,
    output logic              o_prod_ready,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_sum_valid,
    input  logic              i_sum_ready,
    output logic              o_overflow,
    output logic              o_busy,
    output logic [1:0]        o_state
);

    // Handshakes: a term moves on a rising edge with i_prod_valid && o_prod_ready;
    // the result is taken on a rising edge with o_sum_valid && i_sum_ready. Both
    // ready/valid outputs decode registered state only.

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic [ACC_W-1:0] w_sum;
    logic             w_sat;

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .i_acc  (r_acc),
        .i_prod (i_product),
        .o_sum  (w_sum),
        .o_sat  (w_sat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= i_length;
                        r_state <= (i_length == '0) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (i_prod_valid) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_sat;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_sum_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The accumulator doubles as the result register, so Sum holds through IDLE.
    assign o_sum        = r_acc;
    assign o_overflow   = r_ovf;
    assign o_prod_ready = (r_state == ST_ACCUM);
    assign o_sum_valid  = (r_state == ST_DONE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_state      = r_state;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: hand-computed vectors checked with immediate assertions.
module tb_prod_accum;

    localparam int ACC_W = 18;
    localparam int CNT_W = 4;

    logic              clk;
    logic              i_rst_n;
    logic              i_start;
    logic [CNT_W-1:0]  i_length;
    logic [15:0]       i_product;
    logic              i_prod_valid;
    logic              o_prod_ready;
    logic [ACC_W-1:0]  o_sum;
    logic              o_sum_valid;
    logic              i_sum_ready;
    logic              o_overflow;
    logic              o_busy;
    logic [1:0]        o_state;

    int errors = 0;
    int checks = 0;

    prod_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_length     (i_length),
        .i_product    (i_product),
        .i_prod_valid (i_prod_valid),
        .o_prod_ready (o_prod_ready),
        .o_sum        (o_sum),
        .o_sum_valid  (o_sum_valid),
        .i_sum_ready  (i_sum_ready),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy),
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] sum32();
        return {{(32 - ACC_W){o_sum[ACC_W-1]}}, o_sum};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] len);
        i_start  = 1'b1;
        i_length = len;
        tick();
        i_start  = 1'b0;
        i_length = 4'hA;
    endtask

    // Gap cycles drive a junk product with valid low; a stalled block must ignore it.
    task automatic send(input logic [15:0] p, input int gap);
        i_prod_valid = 1'b0;
        i_product    = 16'h7777;
        repeat (gap) tick();
        i_product    = p;
        i_prod_valid = 1'b1;
        tick();
        i_prod_valid = 1'b0;
    endtask

    task automatic finish_done(input string tag, input logic signed [31:0] exp_sum);
        i_sum_ready = 1'b1;
        tick();
        i_sum_ready = 1'b0;
        chk_val({tag, "_idle_state"}, {30'd0, o_state}, 0);
        chk_bit({tag, "_idle_sum_valid"}, o_sum_valid, 1'b0);
        chk_bit({tag, "_idle_busy"}, o_busy, 1'b0);
        chk_val({tag, "_idle_sum_hold"}, sum32(), exp_sum);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_val({tag, "_sum"}, sum32(), 0);
        chk_bit({tag, "_sum_valid"}, o_sum_valid, 1'b0);
        chk_bit({tag, "_prod_ready"}, o_prod_ready, 1'b0);
        chk_bit({tag, "_overflow"}, o_overflow, 1'b0);
        chk_bit({tag, "_busy"}, o_busy, 1'b0);
        chk_val({tag, "_state"}, {30'd0, o_state}, 0);
    endtask

    initial begin
        i_rst_n      = 1'b1;
        i_start      = 1'b0;
        i_length     = '0;
        i_product    = '0;
        i_prod_valid = 1'b0;
        i_sum_ready  = 1'b0;

        // Asynchronous reset takes effect without a clock edge.
        #2 i_rst_n = 1'b0;
        #1 chk_reset_outputs("reset");

        // Start honoured on the first edge after release; 100 - 50 + 7 = 57.
        tick();
        i_rst_n = 1'b1;
        start_run(4'd3);
        chk_val("l3_state", {30'd0, o_state}, 1);
        chk_bit("l3_prod_ready", o_prod_ready, 1'b1);
        chk_bit("l3_busy", o_busy, 1'b1);
        send(16'd100, 0);
        send(-16'sd50, 0);
        chk_bit("l3_not_done_early", o_sum_valid, 1'b0);
        send(16'd7, 0);
        chk_bit("l3_sum_valid", o_sum_valid, 1'b1);
        chk_val("l3_sum", sum32(), 57);
        chk_bit("l3_overflow", o_overflow, 1'b0);
        chk_bit("l3_prod_ready_off", o_prod_ready, 1'b0);
        finish_done("l3", 57);

        // 15 x 16384 = 245760 clamps to 131071.
        start_run(4'd15);
        for (int k = 0; k < 15; k++) send(16'd16384, 0);
        chk_bit("l15_sum_valid", o_sum_valid, 1'b1);
        chk_val("l15_sum", sum32(), 131071);
        chk_bit("l15_overflow", o_overflow, 1'b1);
        finish_done("l15", 131071);

        // Overflow clears on Start; after clamping, a negative term subtracts from the clamp.
        start_run(4'd6);
        chk_bit("nofreeze_ovf_cleared", o_overflow, 1'b0);
        chk_val("nofreeze_acc_cleared", sum32(), 0);
        for (int k = 0; k < 5; k++) send(16'd32767, 0);
        chk_val("nofreeze_clamped", sum32(), 131071);
        send(16'h8000, 0);
        chk_val("nofreeze_sum", sum32(), 98303);
        chk_bit("nofreeze_overflow", o_overflow, 1'b1);
        finish_done("nofreeze", 98303);

        // Negative clamp: 4 x -32768 lands exactly on the minimum, the 5th overflows.
        start_run(4'd5);
        for (int k = 0; k < 4; k++) send(16'h8000, 0);
        chk_val("neg_at_min", sum32(), -131072);
        chk_bit("neg_at_min_no_ovf", o_overflow, 1'b0);
        send(16'h8000, 0);
        chk_val("neg_sum", sum32(), -131072);
        chk_bit("neg_overflow", o_overflow, 1'b1);
        finish_done("neg", -131072);

        // Stalls between terms: 1000 - 2000 + 3000 - 4000 = -2000.
        start_run(4'd4);
        send(16'd1000, 0);
        send(-16'sd2000, 1);
        chk_val("gap_partial", sum32(), -1000);
        chk_bit("gap_still_ready", o_prod_ready, 1'b1);
        send(16'd3000, 2);
        send(-16'sd4000, 3);
        chk_bit("gap_sum_valid", o_sum_valid, 1'b1);
        chk_val("gap_sum", sum32(), -2000);
        chk_bit("gap_overflow", o_overflow, 1'b0);

        // Held in DONE with Start pulsing: everything stays put.
        for (int k = 0; k < 5; k++) begin
            i_start  = 1'b1;
            i_length = 4'd3;
            tick();
            chk_bit("hold_sum_valid", o_sum_valid, 1'b1);
            chk_val("hold_sum", sum32(), -2000);
            chk_bit("hold_overflow", o_overflow, 1'b0);
            chk_val("hold_state", {30'd0, o_state}, 2);
        end
        i_start = 1'b0;
        finish_done("hold", -2000);

        // Zero-length run completes on the next edge with Sum=0.
        start_run(4'd0);
        chk_bit("len0_sum_valid", o_sum_valid, 1'b1);
        chk_val("len0_sum", sum32(), 0);
        chk_bit("len0_overflow", o_overflow, 1'b0);
        finish_done("len0", 0);

        // Reset mid-accumulation discards the partial sum.
        start_run(4'd5);
        send(16'd300, 0);
        send(16'd400, 0);
        chk_val("midrst_partial", sum32(), 700);
        i_rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        tick();
        i_rst_n = 1'b1;
        start_run(4'd2);
        send(16'd5, 0);
        send(16'd6, 0);
        chk_bit("fresh_sum_valid", o_sum_valid, 1'b1);
        chk_val("fresh_sum", sum32(), 11);
        chk_bit("fresh_overflow", o_overflow, 1'b0);
        finish_done("fresh", 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
